muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Magnitudes are iterated STEP bits per cycle; signs are applied on the FIX edge.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             Start_ID,
  input  logic [2:0]       Op_ID,
  input  logic [WIDTH-1:0] SrcA_ID,
  input  logic [WIDTH-1:0] SrcB_ID,
  output logic             Busy_EX,
  output logic             Done_EX,
  output logic [WIDTH-1:0] Hi_EX,
  output logic [WIDTH-1:0] Lo_EX
);
  localparam int unsigned ITERS = WIDTH / STEP;
  localparam int unsigned CW    = $clog2(ITERS + 1);
  localparam int unsigned AW    = 2 * WIDTH;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic             is_div_q, is_div_d;
  logic             div0_q, div0_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand magnitudes and signs; only MULT/DIV treat operands as signed
  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  always_comb begin
    op_signed = ~Op_ID[0];
    a_neg     = op_signed & SrcA_ID[WIDTH-1];
    b_neg     = op_signed & SrcB_ID[WIDTH-1];
    abs_a     = a_neg ? (-SrcA_ID) : SrcA_ID;
    abs_b     = b_neg ? (-SrcB_ID) : SrcB_ID;
  end

  // One RUN cycle: acc = {upper, lower}; lower holds multiplier or quotient bits
  logic [WIDTH:0]   upr;
  logic [WIDTH-1:0] lwr;
  logic [AW-1:0]    step_acc;
  always_comb begin
    upr = {1'b0, acc_q[AW-1:WIDTH]};
    lwr = acc_q[WIDTH-1:0];
    for (int unsigned i = 0; i < STEP; i++) begin
      if (is_div_q) begin
        upr = {upr[WIDTH-1:0], lwr[WIDTH-1]};
        lwr = {lwr[WIDTH-2:0], 1'b0};
        if (upr >= {1'b0, opd_q}) begin
          upr    = upr - {1'b0, opd_q};
          lwr[0] = 1'b1;
        end
      end else begin
        if (lwr[0]) upr = upr + {1'b0, opd_q};
        lwr = {upr[0], lwr[WIDTH-1:1]};
        upr = {1'b0, upr[WIDTH:1]};
      end
    end
    step_acc = {upr[WIDTH-1:0], lwr};
  end

  // Sign correction; a zero divisor leaves the dividend as remainder
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] fix_hi, fix_lo;
  always_comb begin
    prod   = q_neg_q ? (-acc_q) : acc_q;
    fix_hi = prod[AW-1:WIDTH];
    fix_lo = prod[WIDTH-1:0];
    if (is_div_q) begin
      fix_lo = div0_q ? '1 : (q_neg_q ? (-acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
      fix_hi = r_neg_q ? (-acc_q[AW-1:WIDTH]) : acc_q[AW-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opd_d    = opd_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Start_ID && !flush) begin
          unique case (Op_ID)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              is_div_d = Op_ID[1];
              q_neg_d  = a_neg ^ b_neg;
              cnt_d    = CW'(ITERS);
              state_d  = RUN;
              if (Op_ID[1]) begin
                opd_d   = abs_b;
                acc_d   = {{WIDTH{1'b0}}, abs_a};
                div0_d  = (SrcB_ID == '0);
                r_neg_d = a_neg;
              end else begin
                opd_d   = abs_a;
                acc_d   = {{WIDTH{1'b0}}, abs_b};
                div0_d  = 1'b0;
                r_neg_d = 1'b0;
              end
            end
            OP_MTHI: hi_d = SrcA_ID;
            OP_MTLO: lo_d = SrcA_ID;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          hi_d   = fix_hi;
          lo_d   = fix_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opd_q    <= opd_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Busy_EX = busy_q;
  assign Done_EX = done_q;
  assign Hi_EX   = hi_q;
  assign Lo_EX   = lo_q;

endmodule
